// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the fetch port (i_*) and the
// load/store port (d_*). One memory transaction is outstanding at a time.
// Data wins over fetch, except that a fetch request pending through
// MAX_D_STREAK back-to-back data grants is served next.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_req/i_addr/i_kill       fetch request, address, branch flush
//   i_done/i_rdata            fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata data request (load or store)
//   d_done/d_rdata            data completion pulse and load data
//   d_ready                   pipeline stall qualifier (0 = stall MEM stage)
//   m_req/m_we/m_addr/m_wdata memory request side (address/data registered)
//   m_ack/m_rdata             memory completion pulse and read data
//   err                       sticky watchdog error
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a watchdog that
// ends a BUSY state after TIMEOUT_CYCLES cycles without m_ack.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_done,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ack,
  input  logic [31:0]       m_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t     state;
  logic [3:0] d_streak;
  logic       kill_flag;
  logic       busy, grant_d, grant_i, timeout, finish;

  // Fetch is forced only once data has won STREAK_MAX grants in a row
  // while the fetch request was waiting.
  assign grant_d = (state == IDLE) && d_req && !(i_req && d_streak == STREAK_MAX);
  assign grant_i = (state == IDLE) && !grant_d && i_req;
  assign busy    = (state != IDLE);
  assign finish  = busy && (m_ack || timeout);

  assign m_req   = busy;
  // A kill arriving in the completion cycle itself also discards the result.
  assign i_done  = (state == BUSY_I) && finish && !(kill_flag || i_kill);
  assign d_done  = (state == BUSY_D) && finish;
  assign i_rdata = timeout ? 32'h0 : m_rdata;
  assign d_rdata = timeout ? 32'h0 : m_rdata;
  assign d_ready = !d_req || d_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d_streak  <= '0;
      kill_flag <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= BUSY_D;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            if (!i_req)                      d_streak <= '0;
            else if (d_streak != STREAK_MAX) d_streak <= d_streak + 4'd1;
          end else if (grant_i) begin
            state     <= BUSY_I;
            m_we      <= 1'b0;
            m_addr    <= i_addr;
            m_wdata   <= '0;
            d_streak  <= '0;
            kill_flag <= i_kill;
          end
        end
        BUSY_I: begin
          if (finish) begin
            state     <= IDLE;
            kill_flag <= 1'b0;
          end else if (i_kill) begin
            kill_flag <= 1'b1;
          end
        end
        BUSY_D: begin
          if (finish) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;

  // tcnt holds the number of ack-less BUSY cycles already elapsed; the
  // cycle that would make it TIMEOUT_CYCLES ends the transaction.
  assign timeout = busy && !m_ack && (tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (!busy || finish) tcnt <= '0;
      else                 tcnt <= tcnt + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (default build, MAX_D_STREAK=4).
// A behavioural memory with programmable ack latency sits on the m_* side;
// expected completions are queued per port when requests are driven and
// checked when the DUT raises i_done / d_done.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 0, i_kill = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic        i_done, d_done, d_ready, m_req, m_we, m_ack, err;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .err(err)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // ---------------- memory model ----------------
  int          lat = 0;
  int          mcnt;
  logic [31:0] mem [256];
  logic [255:0] wr_valid;

  assign m_ack   = m_req && (mcnt == lat);
  assign m_rdata = wr_valid[m_addr[9:2]] ? mem[m_addr[9:2]] : pat(m_addr);

  always @(posedge clk) begin
    if (rst) begin
      mcnt     <= 0;
      wr_valid <= '0;
    end else if (m_ack) begin
      mcnt <= 0;
      if (m_we) begin
        mem[m_addr[9:2]]      <= m_wdata;
        wr_valid[m_addr[9:2]] <= 1'b1;
      end
    end else if (m_req) mcnt <= mcnt + 1;
    else                mcnt <= 0;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t         exp_d_q[$], exp_i_q[$];
  logic [31:0]  sh_mem [256];
  logic [255:0] sh_valid = '0;
  string        order_log = "";
  int           d_done_cyc = 0, i_done_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_d(input logic [31:0] a, input logic we, input logic [31:0] wd);
    exp_t e;
    e.addr  = a; e.we = we; e.wdata = wd;
    e.rdata = sh_valid[a[9:2]] ? sh_mem[a[9:2]] : pat(a);
    if (we) begin
      sh_mem[a[9:2]]   = wd;
      sh_valid[a[9:2]] = 1'b1;
    end
    exp_d_q.push_back(e);
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_t e;
    e.addr  = a; e.we = 1'b0; e.wdata = 32'h0;
    e.rdata = sh_valid[a[9:2]] ? sh_mem[a[9:2]] : pat(a);
    exp_i_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("d_ready", {31'h0, d_ready}, {31'h0, (!d_req || d_done)});
      if (d_done) begin
        d_done_cyc = cyc;
        order_log  = {order_log, "D"};
        if (exp_d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected d_done: got 1 expected 0 (addr %h)", m_addr);
        end else begin
          exp_t e;
          e = exp_d_q.pop_front();
          chk("d m_addr", m_addr, e.addr);
          chk("d m_we", {31'h0, m_we}, {31'h0, e.we});
          if (e.we) chk("d m_wdata", m_wdata, e.wdata);
          else      chk("d_rdata", d_rdata, e.rdata);
        end
      end
      if (i_done) begin
        i_done_cyc = cyc;
        order_log  = {order_log, "I"};
        if (exp_i_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected i_done: got 1 expected 0 (addr %h)", m_addr);
        end else begin
          exp_t e;
          e = exp_i_q.pop_front();
          chk("i m_addr", m_addr, e.addr);
          chk("i m_we", {31'h0, m_we}, 32'h0);
          chk("i_rdata", i_rdata, e.rdata);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    bit          dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    int          lat;
    string       exp_order;  // completion order
    int          exp_first;  // cycles from request to first done
    int          exp_gap;    // cycles from d_done to i_done (0 = n/a)
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    rst = 1'b1;
    i_req = 0; i_kill = 0; d_req = 0; d_we = 0;
    sh_valid = '0;
    exp_d_q.delete(); exp_i_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int base, n, req_cyc;
    logic id, dd;
    string got;
    @(negedge clk); #1;
    base = order_log.len();
    lat  = v.lat;
    if (v.dreq) begin
      d_req = 1; d_we = v.dwe; d_addr = v.daddr; d_wdata = v.dwdata;
      push_d(v.daddr, v.dwe, v.dwdata);
    end
    if (v.ireq) begin
      i_req = 1; i_addr = v.iaddr;
      push_i(v.iaddr);
    end
    req_cyc = cyc;
    n = 0;
    while ((i_req || d_req) && n < 50) begin
      @(negedge clk);
      n++;
      id = i_done; dd = d_done;
      #1;
      if (id) i_req = 0;
      if (dd) d_req = 0;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL vec%0d timeout: got no completion in %0d cycles, required done", k, n);
      i_req = 0; d_req = 0;
    end
    got = order_log.substr(base, order_log.len() - 1);
    checks++;
    if (got != v.exp_order) begin
      errors++;
      $display("FAIL vec%0d order: got '%s' expected '%s'", k, got, v.exp_order);
    end
    chk($sformatf("vec%0d latency", k),
        32'((v.exp_order.substr(0, 0) == "D") ? d_done_cyc - req_cyc : i_done_cyc - req_cyc),
        32'(v.exp_first));
    if (v.exp_gap != 0)
      chk($sformatf("vec%0d d->i gap", k), 32'(i_done_cyc - d_done_cyc), 32'(v.exp_gap));
  endtask

  // ---------------- main ----------------
  initial begin
    int n, nd, base;
    logic id, dd;
    string got;

    vecs[0] = '{0, 32'h0,  1, 0, 32'h100, 32'h0,        3, "D",  4, 0};
    vecs[1] = '{0, 32'h0,  1, 1, 32'h104, 32'hAABBCCDD, 1, "D",  2, 0};
    vecs[2] = '{0, 32'h0,  1, 0, 32'h104, 32'h0,        0, "D",  1, 0};
    vecs[3] = '{1, 32'h40, 0, 0, 32'h0,   32'h0,        0, "I",  1, 0};
    vecs[4] = '{1, 32'h44, 0, 0, 32'h0,   32'h0,        2, "I",  3, 0};
    vecs[5] = '{1, 32'h80, 1, 0, 32'h300, 32'h0,        0, "DI", 1, 2};
    vecs[6] = '{1, 32'h84, 1, 1, 32'h304, 32'h000055AA, 1, "DI", 2, 3};
    vecs[7] = '{1, 32'h88, 1, 0, 32'h304, 32'h0,        2, "DI", 3, 4};

    // Reset state (sampled while rst is still asserted)
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset m_req",   {31'h0, m_req},  32'h0);
    chk("reset m_we",    {31'h0, m_we},   32'h0);
    chk("reset m_addr",  m_addr,          32'h0);
    chk("reset m_wdata", m_wdata,         32'h0);
    chk("reset err",     {31'h0, err},    32'h0);
    chk("reset i_done",  {31'h0, i_done}, 32'h0);
    chk("reset d_done",  {31'h0, d_done}, 32'h0);
    chk("reset d_ready", {31'h0, d_ready}, 32'h1);
    do_reset();

    // Table-driven transactions
    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Starvation: data requests back to back while fetch waits
    do_reset();
    lat = 0;
    base = order_log.len();
    i_req = 1; i_addr = 32'h90; push_i(32'h90);
    d_req = 1; d_we = 0; d_addr = 32'h400; push_d(32'h400, 1'b0, 32'h0);
    n = 0; nd = 0;
    while ((i_req || d_req) && n < 100) begin
      @(negedge clk);
      n++;
      id = i_done; dd = d_done;
      #1;
      if (id) i_req = 0;
      if (dd) begin
        nd++;
        if (nd == 5) d_req = 0;
        else begin
          d_addr = d_addr + 32'h4;
          push_d(d_addr, 1'b0, 32'h0);
        end
      end
    end
    got = order_log.substr(base, order_log.len() - 1);
    checks++;
    if (got != "DDDDID") begin
      errors++;
      $display("FAIL starvation order: got '%s' expected 'DDDDID'", got);
    end
    // Streak must be back to zero: a fresh collision goes to data first
    run_vec(vecs[5], 5);

    // Kill: in-flight fetch discarded, next fetch served normally
    do_reset();
    lat = 2;
    i_req = 1; i_addr = 32'h40;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_req && n < 10);
    chk("kill grant m_req", {31'h0, m_req}, 32'h1);
    #1 i_kill = 1;
    @(negedge clk); #1 i_kill = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_ack && n < 10);
    chk("kill ack seen", {31'h0, m_ack}, 32'h1);
    chk("kill i_done", {31'h0, i_done}, 32'h0);
    #1 i_req = 0;
    @(negedge clk);
    chk("kill m_req drop", {31'h0, m_req}, 32'h0);
    #1;
    base = order_log.len();
    i_req = 1; i_addr = 32'h80; push_i(32'h80);
    n = 0;
    while (i_req && n < 20) begin
      @(negedge clk); n++;
      id = i_done;
      #1 if (id) i_req = 0;
    end
    got = order_log.substr(base, order_log.len() - 1);
    checks++;
    if (got != "I") begin
      errors++;
      $display("FAIL post-kill fetch: got '%s' expected 'I'", got);
    end

    // Store, then reset in BUSY_D
    do_reset();
    lat = 50;
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
    repeat (3) @(negedge clk);
    chk("store m_req",   {31'h0, m_req}, 32'h1);
    chk("store m_we",    {31'h0, m_we},  32'h1);
    chk("store m_addr",  m_addr,  32'h200);
    chk("store m_wdata", m_wdata, 32'h12345678);
    #1 rst = 1; d_req = 0; d_we = 0;
    @(negedge clk);
    chk("rst mid m_req", {31'h0, m_req}, 32'h0);
    chk("rst mid err",   {31'h0, err},   32'h0);
    chk("rst mid d_done", {31'h0, d_done}, 32'h0);
    #1 rst = 0;
    lat = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage fetch port and the MEM-stage load/store port.
- Permits one outstanding memory transaction at a time. Data has priority, with an anti-starvation limit for fetch.
- Produces d_ready, the pipeline stall qualifier driven into the pipeline's data_ready_mem.
- Supports discarding an in-flight fetch on branch flush.

Parameters:
- ADDR_W, 32, address width for all ports.
- MAX_D_STREAK, 4, max consecutive data grants while i_req is pending before fetch is forced (legal range 1..15).
- TIMEOUT_CYCLES, 1024, watchdog limit (used only with MEM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- i_req  in  1  fetch request; held high with i_addr stable until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_kill  in  1  branch flush; the in-flight fetch result is discarded.
- i_done  out  1  one-cycle fetch completion.
- i_rdata  out  32  fetch data, valid when i_done=1.
- d_req  in  1  data request; held high with all d_* inputs stable until d_done.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  32  store data.
- d_done  out  1  one-cycle data completion.
- d_rdata  out  32  load data, valid when d_done=1.
- d_ready  out  1  pipeline stall qualifier; 0 while a data request is pending and not completing.
- m_req  out  1  memory request; held high until m_ack.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address (registered).
- m_wdata  out  32  memory write data (registered).
- m_ack  in  1  one-cycle completion from memory; m_rdata valid in the same cycle.
- m_rdata  in  32  memory read data.
- err  out  1  sticky watchdog error.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, d_streak=0, kill_flag=0.
- Outputs during reset: m_req=0, m_we=0, m_addr=0, m_wdata=0, err=0, i_done=0, d_done=0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE decision (per cycle):
  - If d_req and not (i_req and d_streak==MAX_D_STREAK): grant D.
  - Else if i_req: grant I.
  - Else stay IDLE.
- Grant: in the grant cycle, register address, we (0 for I) and wdata into m_*. The state moves to BUSY_x at the next edge.
- m_req = (state != IDLE). It is 1 from the cycle after the grant until and including the m_ack cycle.
- BUSY_x with m_ack=1:
  - x_done=1 combinationally and x_rdata=m_rdata in that cycle.
  - The next state is IDLE.
  - For a store, d_rdata is don't-care.
- Minimum request-to-done latency is 2 cycles (grant cycle, then m_ack in the first BUSY cycle).
- The requester may drop req or present a new request in the cycle after done. IDLE re-samples in that cycle.
- m_ack while IDLE is ignored.
- d_streak update at each grant decision:
  - D grant with i_req=1: d_streak+1, saturating at MAX_D_STREAK.
  - I grant, or D grant with i_req=0: d_streak=0.
- d_ready = ~d_req | d_done. The arbiter does not add a registered bubble.
- i_kill:
  - If asserted in BUSY_I, or in the IDLE cycle that grants I: set kill_flag.
  - On that transaction's m_ack, i_done stays 0 and kill_flag clears.
  - i_kill in BUSY_D or in IDLE without an I grant has no effect.
- Simultaneous i_req and d_req in IDLE: D wins unless the streak limit applies.
- rst mid-transaction: the state aborts to IDLE and m_req drops the next cycle. The memory controller is reset by the same rst.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entering BUSY_x and counts each BUSY cycle without m_ack.
  - When it reaches TIMEOUT_CYCLES, err is set (sticky until rst), x_done pulses with x_rdata=32'h0, and the state returns to IDLE.
  - A later stray m_ack in IDLE is ignored.
  - A killed fetch that times out suppresses i_done but still sets err.
- MEM_ARB_TIMEOUT_EN undefined: no counter, err tied 0, BUSY waits indefinitely.

Test Plan:
- Single load: d_req=1, d_addr=0x100, we=0; memory acks 3 cycles after m_req with 0xDEADBEEF -> m_addr=0x100, m_we=0, d_done=1 with d_rdata=0xDEADBEEF for one cycle, d_ready=0 until then.
- Collision: i_req and d_req both rise in the same IDLE cycle, 1-cycle memory -> D served first, then I. The I grant occurs in the IDLE cycle after d_done; i_done follows 2 cycles later.
- Starvation: d_req re-asserted continuously and i_req held, MAX_D_STREAK=4 -> exactly 4 D transactions, then 1 I transaction, then D resumes with d_streak=0.
- Kill: i_req at 0x40; i_kill pulses in BUSY_I; m_ack arrives -> i_done stays 0, m_req drops, next i_req at 0x80 is served normally with i_done=1.
- Store then reset: d_we=1, d_wdata=0x12345678 reaches m_wdata; rst asserted in BUSY_D -> next cycle m_req=0, state IDLE, err=0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: no m_ack -> after 16 BUSY cycles err=1 and d_done=1 with d_rdata=0; err stays 1 until rst.
